// File: rtl/line_writeback_buffer_if.sv
// line_writeback_buffer_if: signal bundle between cache, write-back buffer and memory.
// Latency: none, wires only.
// Backpressure: full_wb2cc throttles the cache; ack_mem2wb paces memory writes.
// Ports: master = cache/memory side (drives push, line, ack, probe); slave = the buffer.
interface line_writeback_buffer_if #(
   parameter int WORD_WIDTH = 32,
   parameter int ADR_WIDTH  = 32,
   parameter int WORD_NUM   = 4
);
   logic                           push_cc2wb;
   logic [ADR_WIDTH-1:0]           adr_cc2wb;
   logic [WORD_WIDTH*WORD_NUM-1:0] dat_cc2wb;
   logic                           full_wb2cc;
   logic                           empty_wb2cc;
   logic                           req_wb2mem;
   logic [ADR_WIDTH-1:0]           adr_wb2mem;
   logic [WORD_WIDTH-1:0]          dat_wb2mem;
   logic                           ack_mem2wb;
   logic [ADR_WIDTH-1:0]           lkp_adr_cc2wb;
   logic                           lkp_hit_wb2cc;
   logic [WORD_WIDTH-1:0]          lkp_dat_wb2cc;

   modport master (
      output push_cc2wb, adr_cc2wb, dat_cc2wb, ack_mem2wb, lkp_adr_cc2wb,
      input  full_wb2cc, empty_wb2cc, req_wb2mem, adr_wb2mem, dat_wb2mem,
             lkp_hit_wb2cc, lkp_dat_wb2cc
   );

   modport slave (
      input  push_cc2wb, adr_cc2wb, dat_cc2wb, ack_mem2wb, lkp_adr_cc2wb,
      output full_wb2cc, empty_wb2cc, req_wb2mem, adr_wb2mem, dat_wb2mem,
             lkp_hit_wb2cc, lkp_dat_wb2cc
   );
endinterface

// File: rtl/line_writeback_buffer.sv
// line_writeback_buffer: DEPTH-entry FIFO of evicted dirty lines, drained to memory one word per ack.
// Latency: req_wb2mem rises the cycle after a push into an empty buffer; a line needs WORD_NUM acks.
// Backpressure: pushes are dropped while full_wb2cc=1; the current word is held until ack_mem2wb.
// Ports: clk, rst (synchronous, active-high); bus (slave modport) carrying the cache push side,
//        the memory write side and the lookup probe.
// Option: define WB_LOOKUP_FWD_EN to forward buffered words on a lookup probe; otherwise the
//         lookup outputs are tied to 0.
module line_writeback_buffer #(
   parameter int WORD_WIDTH = 32,
   parameter int ADR_WIDTH  = 32,
   parameter int WORD_NUM   = 4,
   parameter int DEPTH      = 2
) (
   input logic                    clk,
   input logic                    rst,
   line_writeback_buffer_if.slave bus
);
   localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W    = $clog2(DEPTH) + 1;
   localparam int WRD_W    = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;
   localparam int BYTE_W   = $clog2(WORD_WIDTH / 8);
   localparam int LINE_LSB = WRD_W + BYTE_W;
   localparam int TAG_W    = ADR_WIDTH - LINE_LSB;
   localparam int LINE_W   = WORD_WIDTH * WORD_NUM;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [LINE_W-1:0] dat;
   } entry_t;

   typedef enum logic {IDLE, DRAIN} state_t;

   entry_t           mem [DEPTH];
   entry_t           head;
   state_t           state;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic [WRD_W-1:0] word_cnt;
   logic             full;
   logic             push_acc;
   logic             pop;
   logic             unused_bits;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full      = (count == CNT_W'(DEPTH));
   // A push while full is dropped even if the head pops this same cycle.
   assign push_acc  = bus.push_cc2wb && !full;
   assign pop       = (state == DRAIN) && bus.ack_mem2wb && (word_cnt == WRD_W'(WORD_NUM - 1));
   assign count_nxt = count + CNT_W'(push_acc) - CNT_W'(pop);
   assign head      = mem[rd_ptr];

   assign bus.full_wb2cc  = full;
   assign bus.empty_wb2cc = (count == '0);
   assign bus.req_wb2mem  = (state == DRAIN);
   assign bus.adr_wb2mem  = (state == DRAIN) ? {head.tag, word_cnt, {BYTE_W{1'b0}}} : '0;
   assign bus.dat_wb2mem  = (state == DRAIN) ? head.dat[int'(word_cnt)*WORD_WIDTH +: WORD_WIDTH] : '0;

   // Line storage carries no reset; validity is tracked purely by count and pointers.
   always_ff @(posedge clk) begin
      if (!rst && push_acc) begin
         mem[wr_ptr] <= {bus.adr_cc2wb[ADR_WIDTH-1:LINE_LSB], bus.dat_cc2wb};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         word_cnt <= '0;
      end else begin
         count <= count_nxt;
         if (push_acc) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)      rd_ptr <= ptr_inc(rd_ptr);
         case (state)
            IDLE: begin
               word_cnt <= '0;
               // Looking at the push directly gets req up the very next cycle.
               if (count != '0 || push_acc) state <= DRAIN;
            end
            DRAIN: begin
               if (bus.ack_mem2wb) begin
                  if (pop) begin
                     word_cnt <= '0;
                     // Stay in DRAIN when another line is waiting: no bubble between lines.
                     if (count_nxt == '0) state <= IDLE;
                  end else begin
                     word_cnt <= word_cnt + WRD_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef WB_LOOKUP_FWD_EN
   logic [TAG_W-1:0]      lkp_tag;
   logic [WRD_W-1:0]      lkp_word;
   logic [PTR_W:0]        lkp_sum;
   logic [PTR_W-1:0]      lkp_idx;
   logic                  lkp_hit;
   logic [WORD_WIDTH-1:0] lkp_dat;

   assign lkp_tag  = bus.lkp_adr_cc2wb[ADR_WIDTH-1:LINE_LSB];
   assign lkp_word = bus.lkp_adr_cc2wb[LINE_LSB-1:BYTE_W];

   // Walk valid entries oldest to youngest so the youngest match is the one left standing.
   always_comb begin
      lkp_hit = 1'b0;
      lkp_dat = '0;
      lkp_sum = '0;
      lkp_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         lkp_sum = (PTR_W+1)'(rd_ptr) + (PTR_W+1)'(i);
         if (lkp_sum >= (PTR_W+1)'(DEPTH)) lkp_sum = lkp_sum - (PTR_W+1)'(DEPTH);
         lkp_idx = lkp_sum[PTR_W-1:0];
         if ((CNT_W'(i) < count) && (mem[lkp_idx].tag == lkp_tag)) begin
            lkp_hit = 1'b1;
            lkp_dat = mem[lkp_idx].dat[int'(lkp_word)*WORD_WIDTH +: WORD_WIDTH];
         end
      end
   end

   assign bus.lkp_hit_wb2cc = lkp_hit;
   assign bus.lkp_dat_wb2cc = lkp_dat;
   assign unused_bits = ^{bus.adr_cc2wb[LINE_LSB-1:0], bus.lkp_adr_cc2wb[BYTE_W-1:0]};
`else
   assign bus.lkp_hit_wb2cc = 1'b0;
   assign bus.lkp_dat_wb2cc = '0;
   assign unused_bits = ^{bus.adr_cc2wb[LINE_LSB-1:0], bus.lkp_adr_cc2wb};
`endif
endmodule
